// File: rtl/sha256_msg_padder.sv
// Applies SHA-256 message padding to a 32-bit word stream and emits 512-bit blocks with first/last flags.
// Latency: full block valid 1 cycle after its 16th word, 2 cycles after a last word; output held until out_ready_i.
module sha256_msg_padder (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_data_i,
  input  logic         in_last_i,
  input  logic [2:0]   in_nbytes_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [511:0] out_block_o,
  output logic         out_first_o,
  output logic         out_last_o
);

  typedef enum logic [1:0] {ACCEPT, PAD, EMIT, EXTRA} state_t;

  state_t         state_q, state_d;
  logic [3:0]     widx_q;
  logic [60:0]    len_q;
  logic           first_q;
  logic           last_q;
  logic           extra_q;
  logic           pending_q;
  logic [6:0]     b_q;
  logic [511:0]   block_q;
  logic [511:0]   pad_blk;
  logic [511:0]   ext_blk;
  logic [2:0]     nb;
  logic [31:0]    mask;
  logic [63:0]    len_bits;

  assign nb       = (in_nbytes_i > 3'd4) ? 3'd4 : in_nbytes_i;
  assign len_bits = {len_q, 3'b000};

  assign out_block_o = block_q;
  assign out_first_o = out_valid_o & first_q;
  assign out_last_o  = out_valid_o & last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ACCEPT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      ACCEPT: begin
        in_ready_o = !rst_i;
        if (in_valid_i) begin
          if (in_last_i)            state_d = PAD;
          else if (widx_q == 4'd15) state_d = EMIT;
        end
      end
      PAD:   state_d = EMIT;
      EMIT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = extra_q ? EXTRA : ACCEPT;
      end
      EXTRA: state_d = EMIT;
      default: state_d = ACCEPT;
    endcase
  end

  // Left-justified byte mask for the final word.
  always_comb begin
    case (nb)
      3'd0:    mask = 32'h0000_0000;
      3'd1:    mask = 32'hFF00_0000;
      3'd2:    mask = 32'hFFFF_0000;
      3'd3:    mask = 32'hFFFF_FF00;
      default: mask = 32'hFFFF_FFFF;
    endcase
  end

  // b_q == 64 matches no byte, so a full final block passes through unchanged.
  always_comb begin
    pad_blk = block_q;
    for (int k = 0; k < 64; k++) begin
      if (k == int'(b_q))
        pad_blk[32*(k/4) + 31 - 8*(k%4) -: 8] = 8'h80;
      else if (k > int'(b_q) && (k < 56 || b_q > 7'd55))
        pad_blk[32*(k/4) + 31 - 8*(k%4) -: 8] = 8'h00;
    end
    if (b_q <= 7'd55) begin
      pad_blk[479:448] = len_bits[63:32];
      pad_blk[511:480] = len_bits[31:0];
    end
  end

  always_comb begin
    ext_blk          = '0;
    ext_blk[31:0]    = pending_q ? 32'h8000_0000 : 32'h0;
    ext_blk[479:448] = len_bits[63:32];
    ext_blk[511:480] = len_bits[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      widx_q    <= '0;
      len_q     <= '0;
      first_q   <= 1'b1;
      last_q    <= 1'b0;
      extra_q   <= 1'b0;
      pending_q <= 1'b0;
      b_q       <= '0;
      block_q   <= '0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (in_valid_i) begin
            block_q[{widx_q, 5'b0} +: 32] <= in_data_i & (in_last_i ? mask : 32'hFFFF_FFFF);
            len_q  <= len_q + (in_last_i ? {58'd0, nb} : 61'd4);
            widx_q <= widx_q + 4'd1;
            if (in_last_i) b_q <= {1'b0, widx_q, 2'b00} + {4'd0, nb};
          end
        end
        PAD: begin
          block_q <= pad_blk;
          if (b_q <= 7'd55) begin
            last_q  <= 1'b1;
            extra_q <= 1'b0;
          end else begin
            last_q    <= 1'b0;
            extra_q   <= 1'b1;
            pending_q <= (b_q == 7'd64);
          end
        end
        EMIT: begin
          if (out_ready_i) begin
            first_q <= last_q;
            last_q  <= 1'b0;
            if (!extra_q) begin
              widx_q <= '0;
              if (last_q) len_q <= '0;
            end
          end
        end
        EXTRA: begin
          block_q   <= ext_blk;
          last_q    <= 1'b1;
          extra_q   <= 1'b0;
          pending_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream feeder for the HMAC/SHA-256 accelerator. It accepts a message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit bit-length field. It emits complete 512-bit blocks through a valid/ready handshake, together with first/last-block flags. These drive the message, start and new-message controls of the hash wrapper.

## Interface
- No parameters; widths fixed by SHA-256.
- `clk_i` in 1: single clock, all logic rising-edge.
- `rst_i` in 1: synchronous, active-high reset.
- `in_valid_i` in 1: input word valid.
- `in_ready_o` out 1: padder accepts a word this cycle.
- `in_data_i` in 32: message word; first byte in [31:24].
- `in_last_i` in 1: this word ends the message.
- `in_nbytes_i` in 3: valid bytes in the last word, 0..4, left-justified. Ignored unless `in_last_i`. Values 5..7 are treated as 4.
- `out_valid_o` out 1: `out_block_o` holds a complete block.
- `out_ready_i` in 1: consumer takes the block.
- `out_block_o` out 512: word i at [32i+31:32i]; word 0 is the first word of the block.
- `out_first_o` out 1: block is the first of its message.
- `out_last_o` out 1: block is final; it carries the length field.

## Operation
- **State register** holds one of four states: ACCEPT, PAD, EMIT, EXTRA.
- **Counters**
  - `widx` (4 b): word slot in the current block.
  - `len_q` (61 b): byte count of the message. The length field is `{len_q,3'b0}`, taken modulo 2^64.
  - `first_q`: set at reset and after a last block is sent; cleared when a block handshake completes.
- **ACCEPT**
  - `in_ready_o`=1.
  - An accepted word is written to slot `widx`. `len_q` increases by 4, or by `nbytes` on the last word; `widx` then increments.
  - Non-last word in slot 15 -> EMIT with last=0.
  - Last word -> PAD. Record `b` = 4·widx + nbytes (0..64), the byte offset after the data.
  - Unused low bytes of the last word are zeroed.
- **PAD** (exactly 1 cycle)
  - If b ≤ 55: write 0x80 at byte b, zero bytes b+1..55, word14=len[63:32], word15=len[31:0], set last=1, -> EMIT.
  - If 56 ≤ b ≤ 63: write 0x80 at byte b, zero the rest of the block, set last=0 and extra=1 (marker already placed), -> EMIT.
  - If b = 64: leave the block untouched, set last=0 and extra=1 (marker pending), -> EMIT.
- **EMIT**
  - `out_valid_o`=1 and `in_ready_o`=0.
  - Block and flags stay stable until `out_ready_i`.
  - On handshake: if extra -> EXTRA; otherwise clear `widx`, and if last clear `len_q`, then -> ACCEPT.
- **EXTRA** (1 cycle)
  - Zero the block. Word0=0x80000000 if the marker is pending.
  - Words 14/15 get the length; last=1, first=0, clear extra -> EMIT.
- **Byte numbering**: byte k sits in word k/4 at bits [31-8(k%4) -: 8].
- **Reset**
  - state=ACCEPT, `widx`=0, `len_q`=0, `first_q`=1, extra=0, block=0.
  - `out_valid_o`=0, `out_first_o`=0, `out_last_o`=0, `out_block_o`=0.
  - `in_ready_o`=0 while `rst_i` is high, and 1 the cycle after.
  - Reset mid-message (any state) discards all partial data. No block is emitted.

## Timing
- `in_ready_o` and `out_valid_o` decode directly from state. No combinational path from `out_ready_i` to `in_ready_o` within a cycle.
- Non-last word into slot 15 accepted at cycle t -> `out_valid_o` at t+1.
- Last word accepted at t -> PAD at t+1 -> `out_valid_o` at t+2.
- EMIT handshake at t with extra -> EXTRA at t+1 -> `out_valid_o` at t+2.
- EMIT handshake at t without extra -> `in_ready_o`=1 at t+1.
- Throughput: at most one word per cycle; one idle cycle between blocks.
- `out_valid_o` never drops before the handshake. Once `out_valid_o` is high, `out_block_o`, `out_first_o` and `out_last_o` hold until the handshake.

## Test plan
- **"abc"**: one word 0x61626300, last=1, nbytes=3 -> one block. Word0=0x61626380, words 1..14=0, word15=0x00000018, first=1, last=1.
- **Empty message**: last=1, nbytes=0 at slot 0 -> word0=0x80000000, all others 0, first=1, last=1.
- **56 bytes**: 14 full words -> block 1 has word14=0x80000000, word15=0, first=1, last=0. Block 2 is all-zero except word15=0x000001C0, first=0, last=1.
- **64 bytes**: block 1 is raw data, last=0. Block 2 has word0=0x80000000, word15=0x00000200, last=1.
- **Backpressure**: hold `out_ready_i`=0 for 5 cycles in EMIT. Block and flags stay constant, `in_ready_o`=0 throughout, and the handshake completes on cycle 6.
- **Reset in PAD**: assert `rst_i` for one cycle during PAD. No `out_valid_o` follows, then a new "abc" message produces the exact "abc" block with first=1.
